// File: rtl/ble_rx_pkg.sv
// ble_rx_pkg
//   Shared definitions for the BLE RX packet sequencer:
//   - FSM state encoding (SEARCH/HEADER/PAYLOAD/TRAILER)
//   - advertising access address, CRC24 polynomial, header/CRC byte counts
//   - popcount helper used by the access-address correlator
package ble_rx_pkg;

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_HEADER  = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_TRAILER = 2'd3
   } ble_state_e;

   localparam logic [31:0] BLE_ADV_AA     = 32'h8E89BED6;
   // x^24 term implicit; remaining taps x^10+x^9+x^6+x^4+x^3+x+1
   localparam logic [23:0] BLE_CRC24_POLY = 24'h00065B;
   localparam int unsigned BLE_HDR_BYTES  = 2;
   localparam int unsigned BLE_CRC_BYTES  = 3;

   function automatic logic [5:0] popcount32(input logic [31:0] v);
      logic [5:0] c;
      c = 6'd0;
      for (int i = 0; i < 32; i++) begin
         c = c + {5'd0, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/ble_crc24.sv
// ble_crc24
//   Bit-serial BLE CRC24 LFSR, MSB (bit 23) is the next bit to transmit.
//   Ports:
//     clk_i       system clock
//     rst_i       synchronous active-high reset (register -> 0)
//     init_i      load INIT preset (wins over bit_valid_i)
//     bit_valid_i advance the LFSR by one bit
//     bit_in_i    data bit
//     crc_o[23:0] current LFSR contents
module ble_crc24
   import ble_rx_pkg::*;
#(
   parameter logic [23:0] INIT = 24'h555555
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        init_i,
   input  logic        bit_valid_i,
   input  logic        bit_in_i,
   output logic [23:0] crc_o
);

   logic [23:0] crc_q, crc_d;
   logic        fb_s;

   // LFSR next state: preset, shift with feedback, or hold
   always_comb begin
      fb_s  = crc_q[23] ^ bit_in_i;
      crc_d = crc_q;
      if (init_i) begin
         crc_d = INIT;
      end else if (bit_valid_i) begin
         crc_d = {crc_q[22:0], 1'b0} ^ (fb_s ? BLE_CRC24_POLY : 24'd0);
      end else begin
         crc_d = crc_q;
      end
   end

   // LFSR register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         crc_q <= 24'd0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/ble_rx_pkt_ctrl.sv
// ble_rx_pkt_ctrl
//   BLE RX packet sequencer: correlates the access address, then frames
//   header, payload and CRC bits into bytes and flags completion/errors.
//   Optional feature macro: CRC_CHECK_EN (CRC24 check of received trailer).
//   Ports:
//     clk_i, rst_i        clock, synchronous active-high reset
//     en_i                enable; low returns to SEARCH
//     bit_in_i            demodulated bit (LSB-first per byte)
//     bit_valid_i         bit strobe
//     byte_out_o[7:0]     assembled byte, byte_valid_o 1-cycle strobe
//     sync_det_o          pulse on access-address match
//     pkt_busy_o          high while framing a packet
//     pkt_done_o          pulse with the last CRC byte
//     pkt_err_o           pulse on length violation (or CRC fail)
//     state_dbg_o[1:0]    FSM state
module ble_rx_pkt_ctrl
   import ble_rx_pkg::*;
#(
   parameter logic [31:0] ACCESS_ADDR = BLE_ADV_AA,
   parameter int unsigned AA_MAX_ERR  = 1,
   parameter int unsigned MAX_LEN     = 37,
   parameter logic [23:0] CRC_INIT    = 24'h555555
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic       bit_in_i,
   input  logic       bit_valid_i,
   output logic [7:0] byte_out_o,
   output logic       byte_valid_o,
   output logic       sync_det_o,
   output logic       pkt_busy_o,
   output logic       pkt_done_o,
   output logic       pkt_err_o,
   output logic [1:0] state_dbg_o
);

   localparam logic [1:0] S_SEARCH  = ST_SEARCH;
   localparam logic [1:0] S_HEADER  = ST_HEADER;
   localparam logic [1:0] S_PAYLOAD = ST_PAYLOAD;
   localparam logic [1:0] S_TRAILER = ST_TRAILER;

   localparam logic [5:0] AA_MAX_ERR_W = 6'(AA_MAX_ERR);
   localparam logic [7:0] MAX_LEN_B    = 8'(MAX_LEN);
   localparam logic [5:0] HDR_LAST     = 6'(BLE_HDR_BYTES - 1);
   localparam logic [5:0] CRC_LAST     = 6'(BLE_CRC_BYTES - 1);

   logic [1:0]  state_q, state_d;
   logic [31:0] sr_q, sr_d, sr_shift_s;
   logic [7:0]  byte_sr_q, byte_sr_d, byte_shift_s;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [5:0]  byte_cnt_q, byte_cnt_d;
   logic [7:0]  byte_out_q, byte_out_d;
   logic        byte_valid_q, byte_valid_d;
   logic        sync_det_q, sync_det_d;
   logic        pkt_done_q, pkt_done_d;
   logic        pkt_err_q, pkt_err_d;
   logic [5:0]  aa_dist_s;
   logic        aa_match_s;
   logic        crc_fail_s;

   // Correlation uses the post-shift register so a match fires on the last AA bit
   assign sr_shift_s   = {bit_in_i, sr_q[31:1]};
   assign byte_shift_s = {bit_in_i, byte_sr_q[7:1]};
   assign aa_dist_s    = popcount32(sr_shift_s ^ ACCESS_ADDR);
   assign aa_match_s   = (aa_dist_s <= AA_MAX_ERR_W);

`ifdef CRC_CHECK_EN
   logic [23:0] crc_s;
   logic        crc_bad_q, crc_bad_d;
   logic        crc_init_s, crc_feed_s;

   assign crc_init_s = en_i & bit_valid_i & (state_q == S_SEARCH) & aa_match_s;
   // Trailer bits are fed too: with matching bits the LFSR bit 23 always
   // presents the next expected CRC bit.
   assign crc_feed_s = en_i & bit_valid_i & (state_q != S_SEARCH);
   assign crc_fail_s = crc_bad_q | (bit_in_i ^ crc_s[23]);

   ble_crc24 #(.INIT(CRC_INIT)) u_crc (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .init_i      (crc_init_s),
      .bit_valid_i (crc_feed_s),
      .bit_in_i    (bit_in_i),
      .crc_o       (crc_s)
   );

   // Sticky trailer-mismatch flag, cleared at each new sync
   always_comb begin
      crc_bad_d = crc_bad_q;
      if (crc_init_s) begin
         crc_bad_d = 1'b0;
      end else if (crc_feed_s && (state_q == S_TRAILER)) begin
         crc_bad_d = crc_fail_s;
      end else begin
         crc_bad_d = crc_bad_q;
      end
   end

   // Mismatch flag register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         crc_bad_q <= 1'b0;
      end else begin
         crc_bad_q <= crc_bad_d;
      end
   end
`else
   logic unused_crc_init_s;
   assign unused_crc_init_s = ^CRC_INIT;
   assign crc_fail_s        = 1'b0;
`endif

   // FSM, correlator, byte assembly and pulse generation
   always_comb begin
      state_d      = state_q;
      sr_d         = sr_q;
      byte_sr_d    = byte_sr_q;
      bit_cnt_d    = bit_cnt_q;
      byte_cnt_d   = byte_cnt_q;
      byte_out_d   = byte_out_q;
      byte_valid_d = 1'b0;
      sync_det_d   = 1'b0;
      pkt_done_d   = 1'b0;
      pkt_err_d    = 1'b0;
      if (!en_i) begin
         state_d    = S_SEARCH;
         sr_d       = 32'd0;
         byte_sr_d  = 8'd0;
         bit_cnt_d  = 3'd0;
         byte_cnt_d = 6'd0;
      end else if (bit_valid_i) begin
         case (state_q)
            S_SEARCH: begin
               sr_d = sr_shift_s;
               if (aa_match_s) begin
                  state_d    = S_HEADER;
                  sync_det_d = 1'b1;
                  bit_cnt_d  = 3'd0;
                  byte_cnt_d = 6'd0;
               end else begin
                  state_d = S_SEARCH;
               end
            end
            default: begin
               byte_sr_d = byte_shift_s;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  byte_out_d   = byte_shift_s;
                  byte_valid_d = 1'b1;
                  case (state_q)
                     S_HEADER: begin
                        if (byte_cnt_q != HDR_LAST) begin
                           byte_cnt_d = byte_cnt_q + 6'd1;
                        end else if (byte_shift_s > MAX_LEN_B) begin
                           pkt_err_d  = 1'b1;
                           state_d    = S_SEARCH;
                           sr_d       = 32'd0;
                           byte_cnt_d = 6'd0;
                        end else if (byte_shift_s == 8'd0) begin
                           state_d    = S_TRAILER;
                           byte_cnt_d = 6'd0;
                        end else begin
                           state_d    = S_PAYLOAD;
                           byte_cnt_d = byte_shift_s[5:0];
                        end
                     end
                     S_PAYLOAD: begin
                        if (byte_cnt_q == 6'd1) begin
                           state_d    = S_TRAILER;
                           byte_cnt_d = 6'd0;
                        end else begin
                           byte_cnt_d = byte_cnt_q - 6'd1;
                        end
                     end
                     S_TRAILER: begin
                        if (byte_cnt_q == CRC_LAST) begin
                           pkt_done_d = 1'b1;
                           pkt_err_d  = crc_fail_s;
                           state_d    = S_SEARCH;
                           sr_d       = 32'd0;  // packet tail must not re-trigger
                           byte_cnt_d = 6'd0;
                        end else begin
                           byte_cnt_d = byte_cnt_q + 6'd1;
                        end
                     end
                     default: begin
                        state_d = S_SEARCH;
                     end
                  endcase
               end else begin
                  byte_valid_d = 1'b0;
               end
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State and output registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_SEARCH;
         sr_q         <= 32'd0;
         byte_sr_q    <= 8'd0;
         bit_cnt_q    <= 3'd0;
         byte_cnt_q   <= 6'd0;
         byte_out_q   <= 8'd0;
         byte_valid_q <= 1'b0;
         sync_det_q   <= 1'b0;
         pkt_done_q   <= 1'b0;
         pkt_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sr_q         <= sr_d;
         byte_sr_q    <= byte_sr_d;
         bit_cnt_q    <= bit_cnt_d;
         byte_cnt_q   <= byte_cnt_d;
         byte_out_q   <= byte_out_d;
         byte_valid_q <= byte_valid_d;
         sync_det_q   <= sync_det_d;
         pkt_done_q   <= pkt_done_d;
         pkt_err_q    <= pkt_err_d;
      end
   end

   assign byte_out_o   = byte_out_q;
   assign byte_valid_o = byte_valid_q;
   assign sync_det_o   = sync_det_q;
   assign pkt_busy_o   = (state_q != S_SEARCH);
   assign pkt_done_o   = pkt_done_q;
   assign pkt_err_o    = pkt_err_q;
   assign state_dbg_o  = state_q;

endmodule
